// File: rtl/definitions.sv
// Shared types and limits for the data-memory arbiter.
// Pure declarations: no logic, no state.
package definitions;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {REQ_CORE, REQ_HOST} req_id_t;

  localparam int LAT_CNT_W       = 3;
  localparam int MAX_MEM_LATENCY = (1 << LAT_CNT_W) - 1;

  function automatic bit latencyLegal(input int lat);
    return (lat >= 1) && (lat <= MAX_MEM_LATENCY);
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin pick between core and host; purely combinational, zero latency.
// No backpressure of its own: the caller decides when the pick is consumed.
module arb_rr_select
  import definitions::*;
(
  input  logic    core_req,
  input  logic    host_req,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = core_req | host_req;
    grant_id    = REQ_CORE;
    if (core_req && host_req) begin
      // On a tie the side that did not win last time goes first.
      grant_id = (last_grant == REQ_CORE) ? REQ_HOST : REQ_CORE;
    end else if (host_req) begin
      grant_id = REQ_HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and host accesses to one single-port data memory; write done at N+2, read done at N+2+MEM_LATENCY.
// Requesters hold req until their done pulse; a loser keeping req high is granted next.
module dmem_arbiter
  import definitions::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAST_WAIT = LAT_CNT_W'(MEM_LATENCY);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE   = LAT_CNT_W'(1);

  if (!latencyLegal(MEM_LATENCY)) begin : gBadLatency
    $error("dmem_arbiter: MEM_LATENCY %0d outside 1..%0d", MEM_LATENCY, MAX_MEM_LATENCY);
  end

  arb_state_t           state;
  req_id_t              lastGrant;
  req_id_t              grantId;
  req_id_t              selId;
  logic                 selValid;
  logic                 latWe;
  logic [LAT_CNT_W-1:0] latCnt;

  arb_rr_select uSelect (
    .core_req    (core_req),
    .host_req    (host_req),
    .last_grant  (lastGrant),
    .grant_valid (selValid),
    .grant_id    (selId)
  );

  // mem_addr/mem_wdata double as the latched request; they only change at a grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      lastGrant  <= REQ_HOST;
      grantId    <= REQ_CORE;
      latWe      <= 1'b0;
      latCnt     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_done  <= 1'b0;
      host_done  <= 1'b0;
      core_rdata <= '0;
      host_rdata <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      core_done <= 1'b0;
      host_done <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (selValid) begin
            grantId   <= selId;
            lastGrant <= selId;
            if (selId == REQ_HOST) begin
              latWe     <= host_we;
              mem_we    <= host_we;
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
            end else begin
              latWe     <= core_we;
              mem_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end
            mem_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (latWe) begin
            core_done <= (grantId == REQ_CORE);
            host_done <= (grantId == REQ_HOST);
            state     <= ARB_DONE;
          end else begin
            latCnt <= CNT_ONE;
            state  <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (latCnt == LAST_WAIT) begin
            if (grantId == REQ_HOST) begin
              host_rdata <= mem_rdata;
              host_done  <= 1'b1;
            end else begin
              core_rdata <= mem_rdata;
              core_done  <= 1'b1;
            end
            latCnt <= '0;
            state  <= ARB_DONE;
          end else begin
            latCnt <= latCnt + CNT_ONE;
          end
        end
        ARB_DONE: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
